neuron_mac_seq: RTL and testbench
=================================

# neuron_mac_seq

Downstream consumer of the per-neuron weight BRAMs in the ANN datapath. It sequences addresses into one weight BRAM and the matching activation buffer, and multiply-accumulates N_IN signed Q8.8 products. It then adds the neuron bias, rescales, saturates and optionally applies ReLU, and emits one 16-bit neuron output with a single-cycle valid pulse. One instance sits between each weight BRAM and the layer output register.

## Interface

Parameters:
- N_IN, 28: number of inputs per neuron, which equals the weight BRAM depth.
- AW, 5: address width, with 2^AW ≥ N_IN.
- DW, 16: data width of weights, activations, bias and output.
- FRAC, 8: fractional bits of the fixed-point format (Q8.8).
- ACC_W, 40: accumulator width, at least 2·DW + ceil(log2 N_IN) + 1.

Ports:
- CLK, input, 1: the single clock. All state changes on the rising edge.
- RST_N, input, 1: asynchronous, active-low reset.
- START, input, 1: request one neuron evaluation. Sampled only in IDLE.
- BIAS, input, DW: signed Q8.8 bias, latched on the accepted START edge.
- W_ADDR, output, AW: address to the weight BRAM and activation buffer (shared).
- W_EN, output, 1: read enable to both memories. WE on both memories is tied low at the top level.
- W_DO, input, DW: signed weight from the BRAM, valid at the rising edge after the address was issued.
- X_DO, input, DW: signed activation from the activation buffer, with the same timing as W_DO.
- BUSY, output, 1: high from the accepted START until Y_VALID is asserted.
- Y_OUT, output, DW: neuron result, held until the next result.
- Y_VALID, output, 1: one-cycle pulse when Y_OUT is updated.

## Operation

- FSM states and transitions:
  - IDLE → RUN on START.
  - RUN → BIAS after the last product is accumulated.
  - BIAS → OUT.
  - OUT → IDLE.
- IDLE:
  - Outputs: W_EN=0, BUSY=0.
  - On START: the accumulator is cleared, BIAS is latched, the address counter is set to 0, W_EN=1 and W_ADDR=0.
- RUN:
  - Issues addresses 0 through N_IN−1 on consecutive edges.
  - A one-bit pipeline flag marks cycles where W_DO/X_DO are valid.
  - On each flagged edge: acc += sext(W_DO)·sext(X_DO), a full 2·DW signed product.
  - W_EN drops to 0 on the edge that accumulates element N_IN−1.
- BIAS: acc += sext(BIAS) << FRAC.
- OUT:
  - r = acc >>> FRAC (arithmetic shift, floor rounding).
  - r is saturated to the range [−2^(DW−1), 2^(DW−1)−1].
  - The optional ReLU is applied, the result is written to Y_OUT, and Y_VALID=1 for one cycle.
- START while BUSY: ignored, with no queuing and no effect on the operation in progress.
- START asserted again on the cycle after Y_VALID: accepted as a new operation.
- Accumulator overflow cannot occur at the default widths. Saturation happens only at output rescaling.

## Timing

- Reset values:
  - Outputs: W_ADDR=0, W_EN=0, BUSY=0, Y_OUT=0, Y_VALID=0.
  - Internal: FSM state=IDLE, accumulator=0, pipeline flag=0.
- Call the accepting edge of START edge 0.
  - Edge k (0 ≤ k ≤ N_IN−1): W_ADDR=k is driven.
  - The BRAM captures the address on the falling CLK edge. Data is used at edge k+1.
  - Edge N_IN: last accumulate, W_EN←0.
  - Edge N_IN+1: bias added.
  - Edge N_IN+2: Y_OUT and Y_VALID asserted, BUSY←0.
  - Total: N_IN+2 edges from START to Y_VALID (30 at defaults). Throughput is one neuron per N_IN+3 cycles.
- Reset asserted mid-operation: the operation is aborted immediately. W_EN=0, no Y_VALID, Y_OUT=0.
- START and reset release in the same cycle: START is only honoured on a rising edge while RST_N is high.

## Configuration

- NEURON_RELU_EN defined: saturated results below zero are replaced by 0, and positive values pass unchanged.
- NEURON_RELU_EN undefined: the signed saturated result is output directly (linear activation, used by the output layer).

## Structure

- Shared package ann_pkg holds:
  - the DW, FRAC and ACC_W defaults;
  - the FSM state enum (IDLE, RUN, BIAS, OUT);
  - the Q8.8 constants ONE=16'h0100, MAXV=16'h7FFF, MINV=16'h8000.
- One sub-module, neuron_sat_relu, is combinational. It takes ACC_W in and produces DW out, and performs the shift, the saturation and the NEURON_RELU_EN-gated ReLU.
- Address counter, pipeline flag, accumulator and FSM live in neuron_mac_seq.

## Test plan

- All weights and activations 0x0100, BIAS=0 → Y_OUT=0x1C00 (28.0). Y_VALID pulses exactly 30 edges after START, and W_ADDR steps 0..27 once.
- Weights 0x0100, activations 0xFF00 (−1.0), BIAS=0 → Y_OUT=0x0000 with NEURON_RELU_EN, or 0xE400 (−28.0) without it.
- Weights and activations 0x7FFF, BIAS=0x7FFF → Y_OUT=0x7FFF (positive saturation). Weights 0x7FFF and activations 0x8000 without ReLU → Y_OUT=0x8000.
- Weights 0, BIAS=0x0180 → Y_OUT=0x0180 (1.5). A second START pulse at edge 5 is ignored: exactly one Y_VALID, with BUSY continuous.
- RST_N pulled low at edge 10 of an operation → W_EN=0 and Y_OUT=0 immediately, and no Y_VALID. The next START after release produces the correct result at edge 30.
- Back-to-back operation: START reasserted the cycle after Y_VALID with a different bias → second result correct, and no carry-over in the accumulator.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared ANN datapath defaults, neuron FSM encoding and Q8.8 constants.
package ann_pkg;

  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned FRAC_DEF  = 8;
  localparam int unsigned ACC_W_DEF = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    BIAS = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam logic [DW_DEF-1:0] ONE  = 16'h0100;
  localparam logic [DW_DEF-1:0] MAXV = 16'h7FFF;
  localparam logic [DW_DEF-1:0] MINV = 16'h8000;

endpackage

// File: rtl/neuron_sat_relu.sv
// Rescales the Q.16 accumulator back to Q8.8 with floor rounding and saturation.
// Define NEURON_RELU_EN to clamp negative results to zero; otherwise the output is linear.
module neuron_sat_relu
  import ann_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned FRAC  = FRAC_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [DW-1:0]    y_c_o
);

  localparam logic [DW-1:0] POS_LIM = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_LIM = {1'b1, {(DW-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  logic        [ACC_W-DW:0] upper;
  logic        [DW-1:0]     sat;

  assign shifted = acc_i >>> FRAC;
  assign upper   = shifted[ACC_W-1:DW-1];

  // In range only when every bit above the DW-bit sign position matches the sign.
  always_comb begin
    sat = shifted[DW-1:0];
    if (!(&upper) && (|upper)) begin
      sat = shifted[ACC_W-1] ? NEG_LIM : POS_LIM;
    end
  end

`ifdef NEURON_RELU_EN
  assign y_c_o = sat[DW-1] ? '0 : sat;
`else
  assign y_c_o = sat;
`endif

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequences one weight BRAM / activation buffer, accumulates N_IN Q8.8 products,
// adds the bias and emits one saturated neuron output (ReLU via NEURON_RELU_EN).
module neuron_mac_seq
  import ann_pkg::*;
#(
  parameter int unsigned N_IN  = 28,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned FRAC  = FRAC_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [DW-1:0] bias_i,
  output logic [AW-1:0] w_addr_o,
  output logic          w_en_o,
  input  logic [DW-1:0] w_do_i,
  input  logic [DW-1:0] x_do_i,
  output logic          busy_o,
  output logic [DW-1:0] y_out_o,
  output logic          y_valid_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_IN - 1);

  state_e                  state_q;
  logic [AW-1:0]           addr_q;
  logic                    w_en_q;
  logic                    data_vld_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [DW-1:0]           bias_q;
  logic                    busy_q;
  logic [DW-1:0]           y_q;
  logic                    y_valid_q;

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] bias_ext;
  logic [DW-1:0]           y_c;

  assign prod     = (2*DW)'($signed(w_do_i)) * (2*DW)'($signed(x_do_i));
  assign bias_ext = ACC_W'($signed(bias_q)) <<< FRAC;

  neuron_sat_relu #(
    .ACC_W(ACC_W),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_sat_relu (
    .acc_i(acc_q),
    .y_c_o(y_c)
  );

  // data_vld_q marks edges at which the memories present data for the previous address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      w_en_q     <= 1'b0;
      data_vld_q <= 1'b0;
      acc_q      <= '0;
      bias_q     <= '0;
      busy_q     <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q      <= '0;
            bias_q     <= bias_i;
            addr_q     <= '0;
            w_en_q     <= 1'b1;
            data_vld_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (data_vld_q) begin
            acc_q <= acc_q + ACC_W'(prod);
          end
          // The edge that consumes the last address's data also closes the read burst.
          if (addr_q == LAST_ADDR) begin
            addr_q     <= '0;
            w_en_q     <= 1'b0;
            data_vld_q <= 1'b0;
            state_q    <= BIAS;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        BIAS: begin
          acc_q   <= acc_q + bias_ext;
          state_q <= OUT;
        end
        OUT: begin
          y_q       <= y_c;
          y_valid_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w_addr_o  = addr_q;
  assign w_en_o    = w_en_q;
  assign busy_o    = busy_q;
  assign y_out_o   = y_q;
  assign y_valid_o = y_valid_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed self-checking bench for neuron_mac_seq with behavioural BRAM/activation models.
module tb_neuron_mac_seq;
  import ann_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [15:0] bias_i;
  logic [4:0]  w_addr_o;
  logic        w_en_o;
  logic [15:0] w_do_i;
  logic [15:0] x_do_i;
  logic        busy_o;
  logic [15:0] y_out_o;
  logic        y_valid_o;

  logic [15:0] wmem [32];
  logic [15:0] xmem [32];

  int n_pass;
  int n_checks;
  int mon_n;
  bit mon_bad;

  neuron_mac_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .bias_i   (bias_i),
    .w_addr_o (w_addr_o),
    .w_en_o   (w_en_o),
    .w_do_i   (w_do_i),
    .x_do_i   (x_do_i),
    .busy_o   (busy_o),
    .y_out_o  (y_out_o),
    .y_valid_o(y_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories capture the address on the falling edge; data is used at the next rising edge.
  always @(negedge clk) begin
    if (w_en_o) begin
      w_do_i <= wmem[w_addr_o];
      x_do_i <= xmem[w_addr_o];
      if (w_addr_o !== 5'(mon_n)) mon_bad = 1'b1;
      mon_n = mon_n + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1);
  end

  task automatic load(input logic [15:0] w, input logic [15:0] x);
    for (int i = 0; i < 32; i++) begin
      wmem[i] = w;
      xmem[i] = x;
    end
    mon_n   = 0;
    mon_bad = 1'b0;
  endtask

  // Starts one evaluation from a falling edge; returns at the falling edge where y_valid is seen.
  task automatic run_op(input logic [15:0] b, input int extra_edge,
                        output logic [15:0] y, output int lat, output int busy_gaps);
    int e;
    y = '0;
    lat = -1;
    busy_gaps = 0;
    start_i = 1'b1;
    bias_i  = b;
    @(posedge clk);
    e = 0;
    while (e < 100) begin
      @(negedge clk);
      start_i = (extra_edge > 0) && (e == extra_edge - 1);
      if (e == 0) bias_i = ~b;
      if (y_valid_o) begin
        lat = e;
        y   = y_out_o;
        break;
      end
      if (!busy_o) busy_gaps++;
      @(posedge clk);
      e++;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    start_i = 1'b1;
    bias_i  = 16'h1234;
    w_do_i  = '0;
    x_do_i  = '0;
    load(16'h0, 16'h0);
    repeat (2) @(negedge clk);
    n_checks++; if (w_addr_o !== 5'd0) $display("FAIL reset_w_addr: got %h want 00", w_addr_o); else n_pass++;
    n_checks++; if (w_en_o !== 1'b0) $display("FAIL reset_w_en: got %b want 0", w_en_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (y_out_o !== 16'h0) $display("FAIL reset_y_out: got %h want 0000", y_out_o); else n_pass++;
    n_checks++; if (y_valid_o !== 1'b0) $display("FAIL reset_y_valid: got %b want 0", y_valid_o); else n_pass++;
    start_i = 1'b0;
    rst_n   = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] y;
    int lat, gaps;
    load(ONE, ONE);
    run_op(16'h0000, 0, y, lat, gaps);
    n_checks++; if (y !== 16'h1C00) $display("FAIL basic_y: got %h want 1c00", y); else n_pass++;
    n_checks++; if (lat !== 30) $display("FAIL basic_latency: got %0d want 30", lat); else n_pass++;
    n_checks++; if (gaps !== 0) $display("FAIL basic_busy: got %0d idle cycles want 0", gaps); else n_pass++;
    n_checks++; if (mon_n !== 28) $display("FAIL basic_addr_count: got %0d want 28", mon_n); else n_pass++;
    n_checks++; if (mon_bad !== 1'b0) $display("FAIL basic_addr_order: got %b want 0", mon_bad); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL basic_busy_drop: got %b want 0", busy_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (y_valid_o !== 1'b0) $display("FAIL basic_pulse_width: got %b want 0", y_valid_o); else n_pass++;
    n_checks++; if (y_out_o !== 16'h1C00) $display("FAIL basic_hold: got %h want 1c00", y_out_o); else n_pass++;
  endtask

  task automatic test_negative;
    logic [15:0] y, exp;
    int lat, gaps;
`ifdef NEURON_RELU_EN
    exp = 16'h0000;
`else
    exp = 16'hE400;
`endif
    load(ONE, 16'hFF00);
    run_op(16'h0000, 0, y, lat, gaps);
    n_checks++; if (y !== exp) $display("FAIL negative_y: got %h want %h", y, exp); else n_pass++;
    n_checks++; if (lat !== 30) $display("FAIL negative_latency: got %0d want 30", lat); else n_pass++;
  endtask

  task automatic test_saturation;
    logic [15:0] y, exp;
    int lat, gaps;
    load(MAXV, MAXV);
    run_op(16'h7FFF, 0, y, lat, gaps);
    n_checks++; if (y !== MAXV) $display("FAIL sat_pos_y: got %h want %h", y, MAXV); else n_pass++;
`ifdef NEURON_RELU_EN
    exp = 16'h0000;
`else
    exp = MINV;
`endif
    @(negedge clk);
    load(MAXV, MINV);
    run_op(16'h0000, 0, y, lat, gaps);
    n_checks++; if (y !== exp) $display("FAIL sat_neg_y: got %h want %h", y, exp); else n_pass++;
  endtask

  task automatic test_rounding_and_order;
    logic [15:0] y, exp;
    int lat, gaps;
`ifdef NEURON_RELU_EN
    exp = 16'h0000;
`else
    exp = 16'hFFFF;
`endif
    load(16'h0001, 16'hFFFF);
    run_op(16'h0000, 0, y, lat, gaps);
    n_checks++; if (y !== exp) $display("FAIL floor_y: got %h want %h", y, exp); else n_pass++;
    @(negedge clk);
    load(16'h0000, ONE);
    for (int i = 0; i < 28; i++) wmem[i] = 16'(i + 1);
    run_op(16'h0000, 0, y, lat, gaps);
    n_checks++; if (y !== 16'h0196) $display("FAIL ramp_y: got %h want 0196", y); else n_pass++;
    n_checks++; if (mon_bad !== 1'b0) $display("FAIL ramp_addr_order: got %b want 0", mon_bad); else n_pass++;
  endtask

  task automatic test_ignored_start;
    logic [15:0] y;
    int lat, gaps, extra;
    load(16'h0000, ONE);
    run_op(16'h0180, 5, y, lat, gaps);
    n_checks++; if (y !== 16'h0180) $display("FAIL ign_start_y: got %h want 0180", y); else n_pass++;
    n_checks++; if (lat !== 30) $display("FAIL ign_start_latency: got %0d want 30", lat); else n_pass++;
    n_checks++; if (gaps !== 0) $display("FAIL ign_start_busy: got %0d idle cycles want 0", gaps); else n_pass++;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (y_valid_o) extra++;
    end
    n_checks++; if (extra !== 0) $display("FAIL ign_start_extra_valid: got %0d want 0", extra); else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    logic [15:0] y;
    int lat, gaps, vcnt;
    load(ONE, ONE);
    start_i = 1'b1;
    bias_i  = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (w_en_o !== 1'b0) $display("FAIL rst_mid_w_en: got %b want 0", w_en_o); else n_pass++;
    n_checks++; if (y_out_o !== 16'h0) $display("FAIL rst_mid_y_out: got %h want 0000", y_out_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy_o); else n_pass++;
    vcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (y_valid_o) vcnt++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (y_valid_o) vcnt++;
    end
    n_checks++; if (vcnt !== 0) $display("FAIL rst_mid_no_valid: got %0d want 0", vcnt); else n_pass++;
    load(ONE, ONE);
    run_op(16'h0000, 0, y, lat, gaps);
    n_checks++; if (y !== 16'h1C00) $display("FAIL rst_mid_recover_y: got %h want 1c00", y); else n_pass++;
    n_checks++; if (lat !== 30) $display("FAIL rst_mid_recover_latency: got %0d want 30", lat); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] y1, y2;
    int lat1, lat2, gaps;
    @(negedge clk);
    load(ONE, ONE);
    run_op(ONE, 0, y1, lat1, gaps);
    run_op(16'hFE00, 0, y2, lat2, gaps);
    n_checks++; if (y1 !== 16'h1D00) $display("FAIL b2b_first_y: got %h want 1d00", y1); else n_pass++;
    n_checks++; if (y2 !== 16'h1A00) $display("FAIL b2b_second_y: got %h want 1a00", y2); else n_pass++;
    n_checks++; if (lat2 !== 30) $display("FAIL b2b_second_latency: got %0d want 30", lat2); else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    mon_n    = 0;
    mon_bad  = 1'b0;
    test_reset;
    test_basic;
    test_negative;
    test_saturation;
    test_rounding_and_order;
    test_ignored_start;
    test_reset_mid_op;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
